// File: rtl/axi_lite_slave.sv
// AXI-lite responder backed by a flat register file.
// One outstanding write and one outstanding read; the write and read paths are independent.
module axi_lite_slave #(
  parameter int unsigned         DATA_WD   = 8,
  parameter int unsigned         ADDR_WD   = 8,
  parameter int unsigned         NUM_REGS  = 16,
  parameter logic [DATA_WD-1:0]  RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          awvalid,
  input  logic [ADDR_WD-1:0]            awaddr,
  output logic                          awready,
  input  logic                          wvalid,
  input  logic [DATA_WD-1:0]            wdata,
  output logic                          wready,
  output logic                          bvalid,
  output logic [1:0]                    brsp,
  input  logic                          bready,
  input  logic                          arvalid,
  input  logic [ADDR_WD-1:0]            araddr,
  output logic                          arready,
  output logic                          rvalid,
  output logic [DATA_WD-1:0]            rdata,
  output logic [1:0]                    rrsp,
  input  logic                          rready,
  output logic [NUM_REGS*DATA_WD-1:0]   regs_out
);

  localparam int unsigned     CMP_WD     = ADDR_WD + 1;
  localparam logic [CMP_WD-1:0] NUM_REGS_C = CMP_WD'(NUM_REGS);
  localparam logic [1:0]      RSP_OKAY   = 2'b00;
  localparam logic [1:0]      RSP_SLVERR = 2'b10;

  logic               aw_held;
  logic [ADDR_WD-1:0] aw_addr_q;
  logic               w_held;
  logic [DATA_WD-1:0] w_data_q;

  logic               aw_fire;
  logic               w_fire;
  logic               ar_fire;
  logic               r_fire;
  logic               commit;
  logic [ADDR_WD-1:0] wr_addr;
  logic [DATA_WD-1:0] wr_data;
  logic               wr_in_range;
  logic               rd_in_range;
  logic [DATA_WD-1:0] rd_data_c;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid || rready;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

  // Held address/data take priority; otherwise the beat firing this cycle is used directly.
  assign wr_addr     = aw_held ? aw_addr_q : awaddr;
  assign wr_data     = w_held ? w_data_q : wdata;
  assign commit      = (aw_held || aw_fire) && (w_held || w_fire) && (!bvalid || bready);
  assign wr_in_range = {1'b0, wr_addr} < NUM_REGS_C;
  assign rd_in_range = {1'b0, araddr} < NUM_REGS_C;

  // Read mux compares the full address so out-of-range indices never alias.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == ADDR_WD'(i)) rd_data_c = regs_out[i*DATA_WD +: DATA_WD];
    end
  end

  // Write capture and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      bvalid    <= 1'b0;
      brsp      <= 2'b00;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b1;
      brsp    <= wr_in_range ? RSP_OKAY : RSP_SLVERR;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  // Register file; reads in the same cycle see the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_out <= {NUM_REGS{RESET_VAL}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_in_range && (wr_addr == ADDR_WD'(i)))
          regs_out[i*DATA_WD +: DATA_WD] <= wr_data;
      end
    end
  end

  // Read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rrsp   <= 2'b00;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_in_range ? rd_data_c : '0;
      rrsp   <= rd_in_range ? RSP_OKAY : RSP_SLVERR;
    end else if (r_fire) begin
      rvalid <= 1'b0;
    end
  end

endmodule
